// File: rtl/dmem_arbiter_if.sv
// Bundle of the core data port, DMA/debug port and data memory port seen by dmem_arbiter.
// The arbiter takes the slave view; the requesters and memory together take the master view.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dma_valid;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_ready;
    logic [DATA_W-1:0] dma_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_valid, dma_we, dma_addr, dma_wdata,
        output dma_ready, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_valid, dma_we, dma_addr, dma_wdata,
        input  dma_ready, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares a single-ported synchronous-read data memory between the core data port and a DMA port.
// One transaction at a time; DMA starvation is bounded by a saturating lost-arbitration counter.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input logic            clk,
    input logic            reset,
    dmem_arbiter_if.slave  bus
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

    typedef enum logic [1:0] {
        StIdle,
        StCpuResp,
        StDmaResp
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

    logic dma_force;
    logic cpu_done;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        dma_force     = 1'b0;
        cpu_done      = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = {ADDR_W{1'b0}};
        bus.mem_wdata = {DATA_W{1'b0}};
        bus.cpu_rdata = {DATA_W{1'b0}};
        bus.dma_rdata = {DATA_W{1'b0}};
        bus.dma_ready = 1'b0;

        // While reset is high nothing is granted and any pending response is dropped.
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    dma_force = bus.dma_valid && (wait_cnt_q == MaxCnt);
                    if (bus.cpu_req && !dma_force) begin
                        bus.mem_en    = 1'b1;
                        bus.mem_we    = bus.cpu_we;
                        bus.mem_addr  = bus.cpu_addr;
                        bus.mem_wdata = bus.cpu_wdata;
                        if (bus.cpu_we) begin
                            cpu_done = 1'b1;
                        end else begin
                            state_d = StCpuResp;
                        end
                        if (bus.dma_valid && (wait_cnt_q != MaxCnt)) begin
                            wait_cnt_d = wait_cnt_q + 1'b1;
                        end
                    end else if (bus.dma_valid) begin
                        bus.mem_en    = 1'b1;
                        bus.mem_we    = bus.dma_we;
                        bus.mem_addr  = bus.dma_addr;
                        bus.mem_wdata = bus.dma_wdata;
                        wait_cnt_d    = '0;
                        if (bus.dma_we) begin
                            bus.dma_ready = 1'b1;
                        end else begin
                            state_d = StDmaResp;
                        end
                    end
                end
                StCpuResp: begin
                    bus.cpu_rdata = bus.mem_rdata;
                    cpu_done      = 1'b1;
                    state_d       = StIdle;
                end
                StDmaResp: begin
                    bus.dma_rdata = bus.mem_rdata;
                    bus.dma_ready = 1'b1;
                    state_d       = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            if (!bus.dma_valid) begin
                wait_cnt_d = '0;
            end
        end
    end

    assign bus.cpu_stall = bus.cpu_req && !cpu_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule
